// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 LED command controller
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_RSP,
        DONE,
        ERR
    } ps2_ctrl_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;
    localparam int         PS2_RETRY_MAX   = 2;

    // Host-to-device frame after the start bit: {stop, odd parity, data[7:0]}
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_led_cmd_ctrl_if.sv
// rtl/ps2_led_cmd_ctrl_if.sv - host, receiver and pin signals of the LED command controller
interface ps2_led_cmd_ctrl_if;
    logic [2:0] iLED;
    logic       iLEDUpd;
    logic [7:0] iRxByte;
    logic       iRxVld;
    logic       PS2_CLK_IN;
    logic       PS2_DATA_IN;
    logic       oPS2ClkLow;
    logic       oPS2DataLow;
    logic       oBusy;
    logic       oDone;
    logic       oErr;
    logic [2:0] oLEDCur;

    modport master (
        output iLED, iLEDUpd, iRxByte, iRxVld, PS2_CLK_IN, PS2_DATA_IN,
        input  oPS2ClkLow, oPS2DataLow, oBusy, oDone, oErr, oLEDCur
    );

    modport slave (
        input  iLED, iLEDUpd, iRxByte, iRxVld, PS2_CLK_IN, PS2_DATA_IN,
        output oPS2ClkLow, oPS2DataLow, oBusy, oDone, oErr, oLEDCur
    );
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer with falling-edge strobe for one PS/2 line
module ps2_line_sync (
    input  logic CLK,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);
    // sr[0], sr[1] synchronize; sr[2] holds the previous synchronized level
    logic [2:0] sr;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            sr <= 3'b111;
        end else begin
            sr <= {sr[1:0], line};
        end
    end

    assign level = sr[1];
    assign fall  = sr[2] & ~sr[1];
endmodule

// File: rtl/ps2_led_cmd_ctrl.sv
// rtl/ps2_led_cmd_ctrl.sv - sends Set-LED (0xED + LED byte) to a PS/2 keyboard; PS2_RESEND_EN enables per-byte retries
module ps2_led_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic               CLK,
    input logic               reset,
    ps2_led_cmd_ctrl_if.slave bus
);
    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYC - 1);
    localparam logic [31:0] INH_PRE  = 32'(INHIBIT_CYC - 2);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic        DATA_LOW_AT_ENTRY = (INHIBIT_CYC <= 1);

    ps2_ctrl_state_t state;
    logic [31:0]     cnt;
    logic [3:0]      bit_n;
    logic [2:0]      led_q, pend_led, led_cur;
    logic            pend, byte_sel, busy, done, err, clk_low, data_low;
    logic            clk_lvl, clk_fall, data_lvl, data_fall;
    logic            fail, can_retry, rx_ack;
    logic [9:0]      cur_frame;
    logic            unused_lines;

    ps2_line_sync u_clk_sync (
        .CLK   (CLK),
        .reset (reset),
        .line  (bus.PS2_CLK_IN),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .CLK   (CLK),
        .reset (reset),
        .line  (bus.PS2_DATA_IN),
        .level (data_lvl),
        .fall  (data_fall)
    );

    assign unused_lines = clk_lvl ^ data_fall;
    assign cur_frame    = ps2_frame(byte_sel ? {5'b0, led_q} : PS2_CMD_SET_LED);
    assign rx_ack       = bus.iRxVld && (bus.iRxByte == PS2_RSP_ACK);

    always_comb begin
        fail = 1'b0;
        if (state inside {RTS, SHIFT, ACK, WAIT_RSP} && cnt == TO_LAST)
            fail = 1'b1;
        if (state == ACK && clk_fall && data_lvl)
            fail = 1'b1;
        if (state == WAIT_RSP && bus.iRxVld && bus.iRxByte == PS2_RSP_RESEND)
            fail = 1'b1;
    end

`ifdef PS2_RESEND_EN
    logic [1:0] retry;

    // Retries are counted per byte: cleared when a byte is acknowledged or a sequence ends
    always_ff @(posedge CLK) begin
        if (!reset) begin
            retry <= 2'd0;
        end else if (fail && can_retry) begin
            retry <= retry + 2'd1;
        end else if (state inside {IDLE, DONE, ERR} || (state == WAIT_RSP && rx_ack)) begin
            retry <= 2'd0;
        end
    end

    assign can_retry = (retry < 2'(PS2_RETRY_MAX));
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_n    <= '0;
            led_q    <= '0;
            pend_led <= '0;
            led_cur  <= '0;
            pend     <= 1'b0;
            byte_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.iLEDUpd && busy) begin
                pend     <= 1'b1;
                pend_led <= bus.iLED;
            end
            if (fail) begin
                cnt      <= '0;
                clk_low  <= 1'b0;
                data_low <= 1'b0;
                if (can_retry) begin
                    state    <= INHIBIT;
                    clk_low  <= 1'b1;
                    data_low <= DATA_LOW_AT_ENTRY;
                end else begin
                    state <= ERR;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE, ERR: begin
                        cnt <= '0;
                        if (bus.iLEDUpd) begin
                            led_q    <= bus.iLED;
                            err      <= 1'b0;
                            byte_sel <= 1'b0;
                            pend     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= INHIBIT;
                            clk_low  <= 1'b1;
                            data_low <= DATA_LOW_AT_ENTRY;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            state    <= RTS;
                            cnt      <= '0;
                            clk_low  <= 1'b0;
                            data_low <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                            if (cnt == INH_PRE)
                                data_low <= 1'b1;
                        end
                    end
                    RTS: begin
                        cnt <= cnt + 32'd1;
                        if (clk_fall) begin
                            state    <= SHIFT;
                            cnt      <= '0;
                            bit_n    <= 4'd0;
                            data_low <= ~cur_frame[0];
                        end
                    end
                    SHIFT: begin
                        cnt <= cnt + 32'd1;
                        if (clk_fall) begin
                            if (bit_n == 4'd9) begin
                                state <= ACK;
                                cnt   <= '0;
                            end else begin
                                bit_n    <= bit_n + 4'd1;
                                data_low <= ~cur_frame[bit_n + 4'd1];
                            end
                        end
                    end
                    ACK: begin
                        cnt <= cnt + 32'd1;
                        if (clk_fall) begin
                            state <= WAIT_RSP;
                            cnt   <= '0;
                        end
                    end
                    WAIT_RSP: begin
                        cnt <= cnt + 32'd1;
                        if (rx_ack) begin
                            cnt <= '0;
                            if (!byte_sel) begin
                                byte_sel <= 1'b1;
                                state    <= INHIBIT;
                                clk_low  <= 1'b1;
                                data_low <= DATA_LOW_AT_ENTRY;
                            end else begin
                                led_cur <= led_q;
                                state   <= DONE;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        cnt <= '0;
                        // A request arriving in this very cycle is newer than any pending one
                        if (pend || bus.iLEDUpd) begin
                            led_q    <= bus.iLEDUpd ? bus.iLED : pend_led;
                            pend     <= 1'b0;
                            byte_sel <= 1'b0;
                            busy     <= 1'b1;
                            state    <= INHIBIT;
                            clk_low  <= 1'b1;
                            data_low <= DATA_LOW_AT_ENTRY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clk_low  <= 1'b0;
                        data_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.oPS2ClkLow  = clk_low;
    assign bus.oPS2DataLow = data_low;
    assign bus.oBusy       = busy;
    assign bus.oDone       = done;
    assign bus.oErr        = err;
    assign bus.oLEDCur     = led_cur;
endmodule

// File: doc/ps2_led_cmd_ctrl.md
PS2_LED_CMD_CTRL -- requirements
Module: ps2_led_cmd_ctrl

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000: CLK cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000: maximum CLK cycles spent in any single bus-wait state.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports as follows.
REQ-004 CLK  in  1  system clock.
REQ-005 reset  in  1  synchronous reset, active-low.
REQ-006 iLED  in  3  requested LED state {Caps, Num, Scroll}.
REQ-007 iLEDUpd  in  1  one-cycle update request.
REQ-008 iRxByte  in  8  byte from the PS/2 receiver.
REQ-009 iRxVld  in  1  one-cycle strobe; iRxByte valid.
REQ-010 PS2_CLK_IN / PS2_DATA_IN  in  1 each  raw pin levels.
REQ-011 oPS2ClkLow / oPS2DataLow  out  1 each  1 = pull line low (open-drain enable).
REQ-012 oBusy  out  1  sequence in progress.
REQ-013 oDone  out  1  one-cycle success pulse.
REQ-014 oErr  out  1  sticky failure flag.
REQ-015 oLEDCur  out  3  last LED state acknowledged by the keyboard.

Function
REQ-016 FSM states SHALL be IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_RSP, DONE, ERR.
REQ-017 Sequence SHALL send byte 0xED, then byte {5'b0, led_q}, each as a full host-to-device frame.
REQ-018 IDLE or ERR + iLEDUpd: SHALL latch iLED into led_q, clear oErr, set byte_sel=0, enter INHIBIT; oBusy=1 from the next cycle until DONE/ERR.
REQ-019 INHIBIT: oPS2ClkLow=1 for exactly INHIBIT_CYC cycles; oPS2DataLow=1 on the last cycle; then enter RTS.
REQ-020 RTS: release clock; hold data low (start bit); first synchronized PS2_CLK falling edge enters SHIFT with bit n=0.
REQ-021 SHIFT: at each falling edge drive bit n (oPS2DataLow = ~bit): n=0..7 data LSB first, n=8 odd parity, n=9 stop (released); the edge after n=9 enters ACK.
REQ-022 ACK: at the next falling edge, data 0 enters WAIT_RSP; data 1 is a failure.
REQ-023 WAIT_RSP: iRxVld with 0xFA and byte_sel=0 sets byte_sel=1 and enters INHIBIT; with byte_sel=1, loads oLEDCur<=led_q and enters DONE; 0xFE is a failure; any other byte is ignored.
REQ-024 Timeout counter SHALL clear on every state change; reaching TIMEOUT_CYC in RTS/SHIFT/ACK/WAIT_RSP is a failure.
REQ-025 Failure SHALL release both lines, enter ERR, set oErr=1, clear oBusy.
REQ-026 DONE: oDone=1 for one cycle, then IDLE, or INHIBIT with the pending value if pend is set.
REQ-027 iLEDUpd while oBusy SHALL overwrite pend_led and set pend; iLEDUpd in the DONE cycle counts as pending; pend clears when its sequence starts.
REQ-028 PS2_CLK_IN/PS2_DATA_IN SHALL pass a 2-flop synchronizer; falling edge = previous 1, current 0; edges outside RTS/SHIFT/ACK are ignored.
REQ-029 oPS2ClkLow=oPS2DataLow=0 in IDLE, DONE, ERR; iRxVld outside WAIT_RSP is ignored.

Reset
REQ-030 reset=0 at a CLK edge SHALL force IDLE; clear oBusy, oDone, oErr, oPS2ClkLow, oPS2DataLow, oLEDCur, led_q, pend, counters; synchronizer flops to 1.
REQ-031 Reset mid-frame SHALL release both lines on the next CLK edge; no recovery frame is sent.

Configuration
REQ-032 With PS2_RESEND_EN defined: a failure SHALL resend the current byte from INHIBIT, at most 2 retries per byte; the third failure enters ERR. Without it: the first failure enters ERR.

Structure
REQ-033 Package ps2_pkg SHALL hold the state enum ps2_ctrl_state_t, PS2_CMD_SET_LED=8'hED, PS2_RSP_ACK=8'hFA, PS2_RSP_RESEND=8'hFE, PS2_RETRY_MAX=2.
REQ-034 Sub-module ps2_line_sync (2-flop synchronizer + falling-edge strobe) SHALL be instantiated for PS2_CLK and PS2_DATA.

Verification
REQ-035 iLED=3'b111 pulse, keyboard model acks and returns 0xFA twice -> wire bytes 0xED parity 1, 0x07 parity 0; one oDone; oLEDCur=3'b111.
REQ-036 Any request -> oPS2ClkLow high exactly INHIBIT_CYC cycles, oPS2DataLow asserted before clock release.
REQ-037 Model answers 0xED with 0xFE -> no macro: oErr=1, oBusy=0, no oDone; with PS2_RESEND_EN: 0xED resent, sequence completes.
REQ-038 Model never clocks -> failure TIMEOUT_CYC cycles after RTS entry; oErr=1, both lines released.
REQ-039 Second iLEDUpd iLED=3'b010 during SHIFT -> first sequence completes (oLEDCur=7), second follows automatically (oLEDCur=2); two oDone pulses.
REQ-040 reset=0 during SHIFT -> next cycle oPS2ClkLow=oPS2DataLow=0, oBusy=0, state IDLE.
